cmd_config: RTL and testbench
=============================

# cmd_config

Command decoder and configuration register file for the logic-analyzer capture path. Consumes 16-bit host commands from the UART command layer, reads/writes the configuration registers that drive the trigger and capture logic, and dumps a channel's capture RAM queue back to the host one byte at a time. Sits between the comm master and the per-channel RAM queues and trigger blocks.

## Interface
- ENTRIES, 384, capture RAM depth in bytes
- LOG2, 9, RAM address width

- clk  in  1  clock
- clr_cmd_rdy  in  1  reset, asynchronous, active-high
- cmd  in  16  command; [15:14] opcode, [13:8] register address / channel, [7:0] write data
- cmd_rdy  in  1  cmd valid; held until cmd_done
- resp_sent  in  1  1-cycle pulse: current resp byte fully transmitted
- set_capture_done  in  1  sets TrigCfg[5]
- waddr  in  LOG2  capture write pointer (oldest sample location)
- rdataCH1..rdataCH5  in  8 each  RAM read data, valid 1 cycle after addr_ptr
- addr_ptr  out  LOG2  RAM read address, shared by all channels
- TrigCfg  out  6;  CH1TrigCfg..CH5TrigCfg  out  5 each;  decimator  out  4
- VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL, trig_posH, trig_posL  out  8 each
- resp  out  8  response byte;  send_resp  out  1  1-cycle start-transmit pulse
- cmd_done  out  1  1-cycle pulse: command finished, host clears cmd_rdy

## Operation
- Opcodes: 00 read reg, 01 write reg, 10 dump channel, 11 reserved.
- Register map (addr: reg, reset): 00 TrigCfg 0x03; 01–05 CH1–CH5TrigCfg 0x01; 06 decimator 0x0; 07 VIH 0xAA; 08 VIL 0x55; 09 matchH 0x00; 0A matchL 0x00; 0B maskH 0x00; 0C maskL 0x00; 0D baud_cntH 0x06; 0E baud_cntL 0xC8; 0F trig_posH 0x00; 10 trig_posL 0x01. Writes take the low bits of cmd[7:0] matching register width.
- Write: update register, resp=0xA5. Read: resp=register value, zero-extended. Unmapped address or opcode 11: resp=0xEE, no state change.
- Dump: channel = cmd[10:8] (1–5; other values → resp 0xEE). Reads ENTRIES bytes starting at waddr, addr_ptr incrementing, wrapping ENTRIES-1 → 0; each byte sent and acknowledged before the next.
- set_capture_done sets TrigCfg[5]; a host write to 00 overwrites it; if both in the same cycle, set_capture_done wins for bit 5.
- All other outputs reset to 0; addr_ptr resets to 0.

## Timing
- FSM: IDLE, RESP_WAIT, DUMP_RD, DUMP_SEND, DUMP_WAIT.
- IDLE + cmd_rdy, reg op: register update and resp load on that edge; send_resp pulses next cycle; → RESP_WAIT.
- RESP_WAIT + resp_sent: cmd_done pulses 1 cycle; → IDLE.
- IDLE + cmd_rdy, dump: addr_ptr←waddr; → DUMP_RD (1-cycle RAM latency) → DUMP_SEND: resp←rdataCHn, send_resp pulse, addr_ptr increments → DUMP_WAIT.
- DUMP_WAIT + resp_sent: if ENTRIES bytes sent, cmd_done pulse → IDLE; else → DUMP_RD.
- cmd_rdy ignored outside IDLE. resp holds until next load. Reset mid-command aborts to IDLE with registers at reset values.

## Configuration
- CMD_CFG_DUMP_EN: defined → dump opcode implemented as above. Undefined → DUMP states removed, opcode 10 answered 0xEE like a reserved opcode, addr_ptr tied to 0.

## Test plan
- Reset then read all 17 addresses → resp equals reset table (e.g. 0x0D → 0x06, 0x07 → 0xAA).
- cmd 0x4B55, resp_sent pulsed → resp 0xA5, cmd_done; then cmd 0x0B55 → resp 0x55, maskH 0x55.
- cmd 0xC000 and cmd 0x4100|addr 0x3F → resp 0xEE, no register change.
- RAM preloaded with byte i at address i, waddr=5, cmd 0x8100 → 384 bytes 0x05,0x06,…,0x7F (address 383 → byte 0x7F), wrap, ending at address 4; exactly one cmd_done.
- set_capture_done pulse → TrigCfg 0x23; simultaneous write 0x4000 → TrigCfg 0x20.
- Assert clr_cmd_rdy mid-dump → FSM IDLE, send_resp 0, registers at reset values.

Source files
------------

// File: rtl/cmd_config.sv
// cmd_config: host command decoder, configuration register file and capture RAM dump.
// Define CMD_CFG_DUMP_EN to build the channel-dump opcode; otherwise opcode 10 answers 0xEE.
module cmd_config #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned LOG2    = 9
) (
  input  logic            clk,
  input  logic            clr_cmd_rdy,
  input  logic [15:0]     cmd,
  input  logic            cmd_rdy,
  input  logic            resp_sent,
  input  logic            set_capture_done,
  input  logic [LOG2-1:0] waddr,
  input  logic [7:0]      rdataCH1,
  input  logic [7:0]      rdataCH2,
  input  logic [7:0]      rdataCH3,
  input  logic [7:0]      rdataCH4,
  input  logic [7:0]      rdataCH5,
  output logic [LOG2-1:0] addr_ptr,
  output logic [5:0]      TrigCfg,
  output logic [4:0]      CH1TrigCfg,
  output logic [4:0]      CH2TrigCfg,
  output logic [4:0]      CH3TrigCfg,
  output logic [4:0]      CH4TrigCfg,
  output logic [4:0]      CH5TrigCfg,
  output logic [3:0]      decimator,
  output logic [7:0]      VIH,
  output logic [7:0]      VIL,
  output logic [7:0]      matchH,
  output logic [7:0]      matchL,
  output logic [7:0]      maskH,
  output logic [7:0]      maskL,
  output logic [7:0]      baud_cntH,
  output logic [7:0]      baud_cntL,
  output logic [7:0]      trig_posH,
  output logic [7:0]      trig_posL,
  output logic [7:0]      resp,
  output logic            send_resp,
  output logic            cmd_done
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RESP_WAIT = 3'd1;

  logic [2:0]      state_q, state_d;
  logic [7:0]      resp_q, resp_d;
  logic            send_resp_q, send_resp_d;
  logic            cmd_done_q, cmd_done_d;
  logic [5:0]      trig_cfg_q, trig_cfg_d;
  logic [4:0][4:0] ch_cfg_q, ch_cfg_d;
  logic [3:0]      decimator_q, decimator_d;
  // Byte-wide registers, index 0 is address 0x07 (VIH) through index 9 at 0x10 (trig_posL).
  logic [9:0][7:0] byte_q, byte_d;

  logic [1:0] opcode;
  logic [5:0] reg_addr;
  logic [7:0] wdata;
  logic [2:0] ch_idx;
  logic [3:0] byte_idx;
  logic       reg_hit;
  logic [7:0] rd_data;

  assign opcode   = cmd[15:14];
  assign reg_addr = cmd[13:8];
  assign wdata    = cmd[7:0];
  assign ch_idx   = 3'(reg_addr - 6'd1);
  assign byte_idx = 4'(reg_addr - 6'd7);

  always_comb begin
    reg_hit = 1'b1;
    rd_data = 8'h00;
    if (reg_addr == 6'h00)      rd_data = {2'b00, trig_cfg_q};
    else if (reg_addr <= 6'h05) rd_data = {3'b000, ch_cfg_q[ch_idx]};
    else if (reg_addr == 6'h06) rd_data = {4'h0, decimator_q};
    else if (reg_addr <= 6'h10) rd_data = byte_q[byte_idx];
    else                        reg_hit = 1'b0;
  end

`ifdef CMD_CFG_DUMP_EN
  localparam logic [1:0]      OP_DUMP   = 2'b10;
  localparam logic [2:0]      DUMP_RD   = 3'd2;
  localparam logic [2:0]      DUMP_SEND = 3'd3;
  localparam logic [2:0]      DUMP_WAIT = 3'd4;
  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   LAST_CNT  = (LOG2+1)'(ENTRIES);

  logic [LOG2-1:0] addr_q, addr_d;
  logic [LOG2:0]   cnt_q, cnt_d;
  logic [2:0]      chan_q, chan_d;
  logic [7:0]      rdata;
  logic            chan_ok;

  assign chan_ok  = (cmd[10:8] >= 3'd1) && (cmd[10:8] <= 3'd5);
  assign addr_ptr = addr_q;

  always_comb begin
    rdata = 8'h00;
    case (chan_q)
      3'd1:    rdata = rdataCH1;
      3'd2:    rdata = rdataCH2;
      3'd3:    rdata = rdataCH3;
      3'd4:    rdata = rdataCH4;
      3'd5:    rdata = rdataCH5;
      default: rdata = 8'h00;
    endcase
  end
`else
  logic unused_dump;
  assign unused_dump = ^{waddr, rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5};
  assign addr_ptr    = '0;
`endif

  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    send_resp_d = 1'b0;
    cmd_done_d  = 1'b0;
    trig_cfg_d  = trig_cfg_q;
    ch_cfg_d    = ch_cfg_q;
    decimator_d = decimator_q;
    byte_d      = byte_q;
`ifdef CMD_CFG_DUMP_EN
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    chan_d      = chan_q;
`endif
    case (state_q)
      IDLE: begin
        // cmd_rdy is still high while cmd_done is out; do not re-accept it.
        if (cmd_rdy && !cmd_done_q) begin
          state_d     = RESP_WAIT;
          send_resp_d = 1'b1;
          resp_d      = RESP_ERR;
          if (opcode == OP_READ && reg_hit) begin
            resp_d = rd_data;
          end else if (opcode == OP_WRITE && reg_hit) begin
            resp_d = RESP_ACK;
            if (reg_addr == 6'h00)      trig_cfg_d         = wdata[5:0];
            else if (reg_addr <= 6'h05) ch_cfg_d[ch_idx]   = wdata[4:0];
            else if (reg_addr == 6'h06) decimator_d        = wdata[3:0];
            else                        byte_d[byte_idx]   = wdata;
          end
`ifdef CMD_CFG_DUMP_EN
          else if (opcode == OP_DUMP && chan_ok) begin
            state_d     = DUMP_RD;
            send_resp_d = 1'b0;
            resp_d      = resp_q;
            addr_d      = waddr;
            cnt_d       = '0;
            chan_d      = cmd[10:8];
          end
`endif
        end
      end
      RESP_WAIT: begin
        if (resp_sent) begin
          cmd_done_d = 1'b1;
          state_d    = IDLE;
        end
      end
`ifdef CMD_CFG_DUMP_EN
      DUMP_RD: state_d = DUMP_SEND;
      DUMP_SEND: begin
        resp_d      = rdata;
        send_resp_d = 1'b1;
        addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        cnt_d       = cnt_q + 1'b1;
        state_d     = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (resp_sent) begin
          if (cnt_q == LAST_CNT) begin
            cmd_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = DUMP_RD;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Capture-done has priority over a same-cycle host write of TrigCfg.
    if (set_capture_done) trig_cfg_d[5] = 1'b1;
  end

  always_ff @(posedge clk or posedge clr_cmd_rdy) begin
    if (clr_cmd_rdy) begin
      state_q     <= IDLE;
      resp_q      <= '0;
      send_resp_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      trig_cfg_q  <= 6'h03;
      ch_cfg_q    <= {5{5'h01}};
      decimator_q <= '0;
      byte_q      <= {8'h01, 8'h00, 8'hC8, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'hAA};
`ifdef CMD_CFG_DUMP_EN
      addr_q      <= '0;
      cnt_q       <= '0;
      chan_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      resp_q      <= resp_d;
      send_resp_q <= send_resp_d;
      cmd_done_q  <= cmd_done_d;
      trig_cfg_q  <= trig_cfg_d;
      ch_cfg_q    <= ch_cfg_d;
      decimator_q <= decimator_d;
      byte_q      <= byte_d;
`ifdef CMD_CFG_DUMP_EN
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      chan_q      <= chan_d;
`endif
    end
  end

  assign resp       = resp_q;
  assign send_resp  = send_resp_q;
  assign cmd_done   = cmd_done_q;
  assign TrigCfg    = trig_cfg_q;
  assign CH1TrigCfg = ch_cfg_q[0];
  assign CH2TrigCfg = ch_cfg_q[1];
  assign CH3TrigCfg = ch_cfg_q[2];
  assign CH4TrigCfg = ch_cfg_q[3];
  assign CH5TrigCfg = ch_cfg_q[4];
  assign decimator  = decimator_q;
  assign VIH        = byte_q[0];
  assign VIL        = byte_q[1];
  assign matchH     = byte_q[2];
  assign matchL     = byte_q[3];
  assign maskH      = byte_q[4];
  assign maskL      = byte_q[5];
  assign baud_cntH  = byte_q[6];
  assign baud_cntL  = byte_q[7];
  assign trig_posH  = byte_q[8];
  assign trig_posL  = byte_q[9];

endmodule

// File: tb/tb_cmd_config.sv
// tb_cmd_config: random host commands checked against a register-map and RAM model of cmd_config.
// Dump expectations follow CMD_CFG_DUMP_EN so the bench matches either build of the design.
module tb_cmd_config;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic            clk = 1'b0;
  logic            clr_cmd_rdy;
  logic [15:0]     cmd;
  logic            cmd_rdy, resp_sent, set_capture_done;
  logic [LOG2-1:0] waddr, addr_ptr;
  logic [7:0]      rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5;
  logic [5:0]      TrigCfg;
  logic [4:0]      CH1TrigCfg, CH2TrigCfg, CH3TrigCfg, CH4TrigCfg, CH5TrigCfg;
  logic [3:0]      decimator;
  logic [7:0]      VIH, VIL, matchH, matchL, maskH, maskL;
  logic [7:0]      baud_cntH, baud_cntL, trig_posH, trig_posL, resp;
  logic            send_resp, cmd_done;

  always #5 clk = ~clk;

  cmd_config #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .resp_sent(resp_sent), .set_capture_done(set_capture_done), .waddr(waddr),
    .rdataCH1(rdataCH1), .rdataCH2(rdataCH2), .rdataCH3(rdataCH3), .rdataCH4(rdataCH4),
    .rdataCH5(rdataCH5), .addr_ptr(addr_ptr), .TrigCfg(TrigCfg),
    .CH1TrigCfg(CH1TrigCfg), .CH2TrigCfg(CH2TrigCfg), .CH3TrigCfg(CH3TrigCfg),
    .CH4TrigCfg(CH4TrigCfg), .CH5TrigCfg(CH5TrigCfg), .decimator(decimator),
    .VIH(VIH), .VIL(VIL), .matchH(matchH), .matchL(matchL), .maskH(maskH), .maskL(maskL),
    .baud_cntH(baud_cntH), .baud_cntL(baud_cntL), .trig_posH(trig_posH),
    .trig_posL(trig_posL), .resp(resp), .send_resp(send_resp), .cmd_done(cmd_done)
  );

  int         checks = 0;
  int         errors = 0;
  int         sent_cnt = 0;
  int         done_cnt = 0;
  bit         chk_en = 1'b0;
  logic [7:0] m [17];
  logic [7:0] exp_q [$];

  function automatic logic [7:0] ram_byte(int ch, int a);
    logic [7:0] lo;
    lo = 8'(a);
    if (ch == 1) return lo;
    return (lo ^ 8'(ch * 37)) + 8'(ch);
  endfunction

  // Per-channel capture RAM with one cycle of read latency.
  always @(posedge clk) begin
    rdataCH1 <= ram_byte(1, int'(addr_ptr));
    rdataCH2 <= ram_byte(2, int'(addr_ptr));
    rdataCH3 <= ram_byte(3, int'(addr_ptr));
    rdataCH4 <= ram_byte(4, int'(addr_ptr));
    rdataCH5 <= ram_byte(5, int'(addr_ptr));
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] reg_mask(int a);
    if (a == 0) return 8'h3F;
    if (a <= 5) return 8'h1F;
    if (a == 6) return 8'h0F;
    return 8'hFF;
  endfunction

  task automatic model_reset();
    m[0] = 8'h03;
    for (int a = 1; a <= 5; a++) m[a] = 8'h01;
    m[6] = 8'h00; m[7] = 8'hAA; m[8] = 8'h55;
    for (int a = 9; a <= 12; a++) m[a] = 8'h00;
    m[13] = 8'h06; m[14] = 8'hC8; m[15] = 8'h00; m[16] = 8'h01;
  endtask

  // Applies one accepted command to the model and lists the bytes the host must receive.
  task automatic model_cmd(input logic [15:0] c, input bit s);
    int op, a, ch;
    op = int'(c[15:14]);
    a  = int'(c[13:8]);
    ch = int'(c[10:8]);
    exp_q.delete();
    if (op == 0 && a <= 16) exp_q.push_back(m[a]);
    else if (op == 1 && a <= 16) begin
      m[a] = c[7:0] & reg_mask(a);
      exp_q.push_back(8'hA5);
    end
`ifdef CMD_CFG_DUMP_EN
    else if (op == 2 && ch >= 1 && ch <= 5) begin
      for (int k = 0; k < ENTRIES; k++) exp_q.push_back(ram_byte(ch, (int'(waddr) + k) % ENTRIES));
    end
`endif
    else exp_q.push_back(8'hEE);
    if (s) m[0] = m[0] | 8'h20;
  endtask

  function automatic logic [127:0] model_vec();
    return 128'({m[0][5:0], m[1][4:0], m[2][4:0], m[3][4:0], m[4][4:0], m[5][4:0], m[6][3:0],
                 m[7], m[8], m[9], m[10], m[11], m[12], m[13], m[14], m[15], m[16]});
  endfunction

  function automatic logic [127:0] dut_vec();
    return 128'({TrigCfg, CH1TrigCfg, CH2TrigCfg, CH3TrigCfg, CH4TrigCfg, CH5TrigCfg, decimator,
                 VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL, trig_posH,
                 trig_posL});
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (send_resp) sent_cnt++;
      if (cmd_done) done_cnt++;
      chk("regs", dut_vec(), model_vec());
`ifndef CMD_CFG_DUMP_EN
      chk("addr_ptr_tied", 128'(addr_ptr), 128'(0));
`endif
    end
  end

  task automatic do_cmd(input logic [15:0] c, input bit s, output logic [7:0] first,
                        output logic [7:0] last);
    int n, base_s, base_d, lat;
    @(negedge clk);
    cmd = c; cmd_rdy = 1'b1; set_capture_done = s;
    @(posedge clk);
    model_cmd(c, s);
    base_s = sent_cnt;
    base_d = done_cnt;
    @(negedge clk);
    set_capture_done = 1'b0;
    cmd = 16'($urandom);
    lat = (exp_q.size() > 1) ? 2 : 0;
    first = 8'h00;
    last  = 8'h00;
    for (int i = 0; i < exp_q.size(); i++) begin
      n = 0;
      while (!send_resp && n < 12) begin @(negedge clk); n++; end
      chk("send_latency", 128'(n), 128'(lat));
      if (n >= 12) break;
      chk("resp", 128'(resp), 128'(exp_q[i]));
      if (i == 0) first = resp;
      last = resp;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      resp_sent = 1'b1;
      @(negedge clk);
      resp_sent = 1'b0;
    end
    n = 0;
    while (!cmd_done && n < 8) begin @(negedge clk); n++; end
    chk("done_latency", 128'(n), 128'(0));
    cmd_rdy = 1'b0;
    @(negedge clk);
    #1;
    chk("send_count", 128'(sent_cnt - base_s), 128'(exp_q.size()));
    chk("done_count", 128'(done_cnt - base_d), 128'(1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  f, l;
    logic [15:0] midc, c;
    int          n, nack, ndump, r;
    bit          s;
    clr_cmd_rdy = 1'b1; cmd = '0; cmd_rdy = 1'b0; resp_sent = 1'b0;
    set_capture_done = 1'b0; waddr = '0; ndump = 0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_resp", 128'(resp), 128'(0));
    chk("rst_send_resp", 128'(send_resp), 128'(0));
    chk("rst_cmd_done", 128'(cmd_done), 128'(0));
    chk("rst_addr_ptr", 128'(addr_ptr), 128'(0));
    #2 clr_cmd_rdy = 1'b0;

    for (int a = 0; a <= 16; a++) begin
      do_cmd({2'b00, 6'(a), 8'h00}, 1'b0, f, l);
      if (a == 13) chk("rd_baudH_lit", 128'(f), 128'(8'h06));
      if (a == 7) chk("rd_vih_lit", 128'(f), 128'(8'hAA));
    end

    do_cmd(16'h4B55, 1'b0, f, l);
    chk("wr_ack_lit", 128'(f), 128'(8'hA5));
    do_cmd(16'h0B55, 1'b0, f, l);
    chk("rd_maskH_lit", 128'(f), 128'(8'h55));
    chk("maskH_lit", 128'(maskH), 128'(8'h55));
    do_cmd(16'hC000, 1'b0, f, l);
    chk("reserved_lit", 128'(f), 128'(8'hEE));
    do_cmd(16'h7F12, 1'b0, f, l);
    chk("wr_unmapped_lit", 128'(f), 128'(8'hEE));
    do_cmd(16'h1100, 1'b0, f, l);
    chk("rd_unmapped_lit", 128'(f), 128'(8'hEE));

    @(negedge clk); set_capture_done = 1'b1;
    @(posedge clk); m[0] = m[0] | 8'h20;
    @(negedge clk); set_capture_done = 1'b0;
    chk("capture_done_lit", 128'(TrigCfg), 128'(6'h23));
    do_cmd(16'h4000, 1'b1, f, l);
    chk("capture_wins_lit", 128'(TrigCfg), 128'(6'h20));

    waddr = 9'd5;
    do_cmd(16'h8100, 1'b0, f, l);
`ifdef CMD_CFG_DUMP_EN
    chk("dump_first_lit", 128'(f), 128'(8'h05));
    chk("dump_last_lit", 128'(l), 128'(8'h04));
`else
    chk("dump_off_lit", 128'(f), 128'(8'hEE));
`endif
    do_cmd(16'h8600, 1'b0, f, l);
    chk("dump_badch_lit", 128'(f), 128'(8'hEE));

    for (int it = 0; it < 60; it++) begin
      c = 16'($urandom);
      r = $urandom_range(0, 99);
      if (r < 40) c[15:14] = 2'b00;
      else if (r < 75) c[15:14] = 2'b01;
      else if (r < 80) c[15:14] = 2'b10;
      else c[15:14] = 2'b11;
      if ($urandom_range(0, 3) != 0) c[13:8] = 6'($urandom_range(0, 18));
      if (c[15:14] == 2'b10) begin
        if (ndump >= 2) c[15:14] = 2'b00;
        else begin
          ndump++;
          waddr = 9'($urandom_range(0, ENTRIES - 1));
        end
      end
      s = ($urandom_range(0, 4) == 0);
      do_cmd(c, s, f, l);
    end

    // Reset in the middle of a command must abort it and restore every register.
    do_cmd(16'h4713, 1'b0, f, l);
`ifdef CMD_CFG_DUMP_EN
    midc = 16'h8200;
    waddr = 9'd100;
`else
    midc = 16'h4712;
`endif
    @(negedge clk); cmd = midc; cmd_rdy = 1'b1;
    @(posedge clk); model_cmd(midc, 1'b0);
    @(negedge clk);
    nack = (exp_q.size() > 1) ? 3 : 0;
    for (int i = 0; i < nack; i++) begin
      n = 0;
      while (!send_resp && n < 12) begin @(negedge clk); n++; end
      chk("mid_resp", 128'(resp), 128'(exp_q[i]));
      resp_sent = 1'b1;
      @(negedge clk);
      resp_sent = 1'b0;
    end
    #2 clr_cmd_rdy = 1'b1;
    model_reset();
    @(negedge clk);
    chk("mid_rst_send_resp", 128'(send_resp), 128'(0));
    chk("mid_rst_cmd_done", 128'(cmd_done), 128'(0));
    chk("mid_rst_addr_ptr", 128'(addr_ptr), 128'(0));
    chk("mid_rst_vih_lit", 128'(VIH), 128'(8'hAA));
    cmd_rdy = 1'b0;
    #2 clr_cmd_rdy = 1'b0;
    do_cmd(16'h0700, 1'b0, f, l);
    chk("post_rst_read_lit", 128'(f), 128'(8'hAA));

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
